// File: rtl/uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_ctrl
//   Command sequencer between a UART core and a combinational ALU.
//   It collects a 3-byte frame from RX: operand A, then operand B, then the
//   opcode. It presents the latched operands to the ALU and captures the
//   result. It then launches one TX byte and waits for TX completion before
//   accepting the next frame.
//   An inter-byte timeout drops a partially received frame so that the next
//   byte is treated as operand A again.
//
// Ports
//   clk            in   1     system clock, rising edge
//   reset          in   1     asynchronous active-high reset
//   i_rx_data      in   DBIT  received byte, valid while i_rx_done=1
//   i_rx_done      in   1     1-cycle pulse: byte received
//   i_alu_result   in   DBIT  combinational ALU output for o_alu_a/b/op
//   i_tx_done      in   1     1-cycle pulse: TX stop bit sent
//   o_alu_a        out  DBIT  latched operand A
//   o_alu_b        out  DBIT  latched operand B
//   o_alu_op       out  OP_W  latched opcode (OP_W LSBs of third byte)
//   o_tx_data      out  DBIT  registered ALU result to transmit
//   o_tx_start     out  1     1-cycle pulse: start TX of o_tx_data
//   o_busy         out  1     high whenever the FSM is not IDLE
//   o_err_timeout  out  1     1-cycle pulse: partial frame dropped by timeout
//   o_err_overrun  out  1     1-cycle pulse: byte dropped during EXEC/SEND/WAIT_TX
// -----------------------------------------------------------------------------
module uart_alu_ctrl #(
  parameter int DBIT    = 8,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 100000,
  parameter int TO_W    = 17
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DBIT-1:0] i_rx_data,
  input  logic            i_rx_done,
  input  logic [DBIT-1:0] i_alu_result,
  input  logic            i_tx_done,
  output logic [DBIT-1:0] o_alu_a,
  output logic [DBIT-1:0] o_alu_b,
  output logic [OP_W-1:0] o_alu_op,
  output logic [DBIT-1:0] o_tx_data,
  output logic            o_tx_start,
  output logic            o_busy,
  output logic            o_err_timeout,
  output logic            o_err_overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q,     state_d;
  logic [TO_W-1:0] to_cnt_q,    to_cnt_d;
  logic [DBIT-1:0] alu_a_q,     alu_a_d;
  logic [DBIT-1:0] alu_b_q,     alu_b_d;
  logic [OP_W-1:0] alu_op_q,    alu_op_d;
  logic [DBIT-1:0] tx_data_q,   tx_data_d;
  logic            tx_start_q,  tx_start_d;
  logic            err_to_q,    err_to_d;
  logic            err_ov_q,    err_ov_d;

  logic            to_hit;

  assign to_hit = (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      to_cnt_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tx_data_d = tx_data_q;
    err_to_d  = 1'b0;
    err_ov_d  = 1'b0;
    // The counter only runs while waiting for B or the opcode; any other
    // state, every accepted byte and a timeout all leave it at zero, which
    // also gives the clear-on-entry behaviour for free.
    to_cnt_d  = '0;
    // Registered decode of SEND: the start pulse appears one cycle after the
    // FSM passes through SEND, i.e. two edges after the opcode byte lands.
    tx_start_d = (state_q == SEND);

    unique case (state_q)
      IDLE: begin
        if (i_rx_done) begin
          alu_a_d = i_rx_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        // A byte in the terminal-count cycle is still accepted.
        if (i_rx_done) begin
          alu_b_d = i_rx_data;
          state_d = GET_OP;
        end else if (to_hit) begin
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      GET_OP: begin
        if (i_rx_done) begin
          alu_op_d = i_rx_data[OP_W-1:0];
          state_d  = EXEC;
        end else if (to_hit) begin
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      EXEC: begin
        tx_data_d = i_alu_result;
        err_ov_d  = i_rx_done;
        state_d   = SEND;
      end
      SEND: begin
        err_ov_d = i_rx_done;
        state_d  = WAIT_TX;
      end
      WAIT_TX: begin
        err_ov_d = i_rx_done;
        if (i_tx_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_alu_a       = alu_a_q;
  assign o_alu_b       = alu_b_q;
  assign o_alu_op      = alu_op_q;
  assign o_tx_data     = tx_data_q;
  assign o_tx_start    = tx_start_q;
  assign o_busy        = (state_q != IDLE);
  assign o_err_timeout = err_to_q;
  assign o_err_overrun = err_ov_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_ctrl
//   Directed bench for uart_alu_ctrl with TIMEOUT=16. The bench supplies a
//   small ALU (6'h20 = add, 6'h22 = sub, anything else = 0). Inputs are
//   driven 1 ns after a rising edge. Outputs are sampled in that same slot,
//   which is after the edge they belong to.
// -----------------------------------------------------------------------------
module tb_uart_alu_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_result;
  logic       tx_done;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy, err_to, err_ov;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_alu_ctrl #(.DBIT(8), .OP_W(6), .TIMEOUT(16), .TO_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_alu_result (alu_result),
    .i_tx_done    (tx_done),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy),
    .o_err_timeout(err_to),
    .o_err_overrun(err_ov)
  );

  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called 1 ns after an edge; the byte is latched at the next edge and the
  // task returns 1 ns after that edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  // Sends A, B, op and checks the result latency up to the end of the start pulse.
  task automatic start_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] res);
    send_byte(a);
    send_byte(b);
    send_byte(op);                       // op latched at edge N
    chk({tag, "_a"}, alu_a, a);
    chk({tag, "_b"}, alu_b, b);
    chk({tag, "_op"}, alu_op, op[5:0]);
    chk({tag, "_exec_nostart"}, tx_start, 1'b0);
    @(posedge clk); #1;                  // edge N+1
    chk({tag, "_txdata"}, tx_data, res);
    chk({tag, "_n1_nostart"}, tx_start, 1'b0);
    @(posedge clk); #1;                  // edge N+2
    chk({tag, "_start"}, tx_start, 1'b1);
    @(posedge clk); #1;                  // edge N+3
    chk({tag, "_start_end"}, tx_start, 1'b0);
    chk({tag, "_busy_wait"}, busy, 1'b1);
  endtask

  task automatic finish_frame(input string tag);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic seen;

    reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    #2;
    chk("t1_reset_outs", {alu_a, alu_b, alu_op, tx_data, tx_start, busy, err_to, err_ov}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t1_busy_after_release", busy, 1'b0);

    // Test 2: basic add.
    start_frame("t2", 8'h05, 8'h03, 8'h20, 8'h08);
    finish_frame("t2");
    $display("t2 frame 05 03 20 -> tx_data %0h", tx_data);

    // Test 1 (async part): reset pulsed mid-cycle clears held outputs at once.
    #3 reset = 1'b1;
    #1;
    chk("t1_async_clear", {alu_a, alu_b, alu_op, tx_data}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    $display("t1 async reset mid-cycle cleared outputs");

    // Test 3: timeout after operand A, then a normal subtract frame.
    send_byte(8'h05);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (err_to) begin
        cyc = i;
        break;
      end
    end
    chk("t3_timeout_cycles", cyc, 16);
    chk("t3_idle_after_to", busy, 1'b0);
    @(posedge clk); #1;
    chk("t3_to_pulse_len", err_to, 1'b0);
    start_frame("t3", 8'h0A, 8'h04, 8'h22, 8'h06);
    finish_frame("t3");
    $display("t3 timeout after %0d cycles, frame 0A 04 22 -> %0h", cyc, tx_data);

    // Byte arriving exactly at terminal count wins; no timeout.
    send_byte(8'h07);
    repeat (15) begin
      @(posedge clk); #1;
    end
    send_byte(8'h02);
    chk("t3b_no_timeout", err_to, 1'b0);
    chk("t3b_still_busy", busy, 1'b1);
    chk("t3b_b_latched", alu_b, 8'h02);
    send_byte(8'h20);
    @(posedge clk); #1;
    chk("t3b_txdata", tx_data, 8'h09);
    repeat (2) begin
      @(posedge clk); #1;
    end
    finish_frame("t3b");
    $display("t3b byte at terminal count accepted, tx_data %0h", tx_data);

    // Test 4: overrun during WAIT_TX.
    start_frame("t4", 8'h10, 8'h01, 8'h20, 8'h11);
    send_byte(8'hAA);
    chk("t4_overrun", err_ov, 1'b1);
    chk("t4_a_kept", alu_a, 8'h10);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= tx_start;
      @(posedge clk); #1;
    end
    chk("t4_ov_pulse_len", err_ov, 1'b0);
    chk("t4_no_restart", seen, 1'b0);
    finish_frame("t4");
    start_frame("t4n", 8'h09, 8'h02, 8'h22, 8'h07);
    finish_frame("t4n");
    $display("t4 overrun flagged, next frame -> %0h", tx_data);

    // Test 5: wrap, then back-to-back frame one cycle after tx_done.
    start_frame("t5", 8'hFF, 8'h01, 8'h20, 8'h00);
    finish_frame("t5");
    start_frame("t5b", 8'h30, 8'h12, 8'h20, 8'h42);
    finish_frame("t5b");
    $display("t5 wrap -> 00, back-to-back frame -> %0h", tx_data);

    // Test 6: reset in GET_OP and in WAIT_TX.
    send_byte(8'h01);
    send_byte(8'h02);
    #3 reset = 1'b1;
    #1;
    chk("t6_getop_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      seen |= tx_start | err_to | err_ov;
    end
    chk("t6_getop_quiet", seen, 1'b0);

    start_frame("t6w", 8'h04, 8'h04, 8'h20, 8'h08);
    #3 reset = 1'b1;
    #1;
    chk("t6_wait_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      seen |= tx_start | err_to | err_ov;
    end
    chk("t6_wait_quiet", seen, 1'b0);
    start_frame("t6n", 8'h20, 8'h05, 8'h22, 8'h1B);
    finish_frame("t6n");
    $display("t6 resets in GET_OP/WAIT_TX, next frame -> %0h", tx_data);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
